mu0_regbank: RTL and testbench
==============================

Name: mu0_regbank

Overview:
- Parametrised multi-register bank for the MU0 datapath; generalises the single 12-bit enabled register to 2**ADDR_W registers of WIDTH bits.
- One write port carries a per-cycle operation: load, increment, decrement or clear.
- Two independent combinational read ports.
- Registered zero and carry flags summarise the last write, for use by the MU0 control unit.

Parameters:
- WIDTH, 12, data width of every register.
- ADDR_W, 2, address width; bank holds NREGS = 2**ADDR_W registers.
- RESET_VAL, 0, value (WIDTH bits) loaded into every register on reset.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- En  input  1  global enable; 0 freezes all state
- WrEn  input  1  write-port request
- WrAddr  input  ADDR_W  target register for the write operation
- Op  input  2  00 load, 01 increment, 10 decrement, 11 clear
- WrData  input  WIDTH  data for load op; ignored for other ops
- RdAddrA  input  ADDR_W  read port A address
- RdDataA  output  WIDTH  contents of register RdAddrA
- RdAddrB  input  ADDR_W  read port B address
- RdDataB  output  WIDTH  contents of register RdAddrB
- Zero  output  1  registered: last written result was all zeros
- Carry  output  1  registered: last increment wrapped or last decrement borrowed

Behaviour:
- Reset: Reset_n=0 immediately (no clock edge) forces every register to RESET_VAL, Zero=1 if RESET_VAL==0 else 0, and Carry=0.
  - Reset asserted mid-operation overrides any write in progress.
  - Release is synchronous to the design: the first write is taken on the first rising Clk with Reset_n=1.
- Write: on rising Clk with Reset_n=1, En=1 and WrEn=1, register[WrAddr] is updated per Op. Latency 1 cycle; the new value is visible on read ports after the edge.
  - Load: R <= WrData. Carry <= 0.
  - Increment: R <= R+1 modulo 2**WIDTH. Carry <= 1 iff R was all ones (wrap to 0), else 0.
  - Decrement: R <= R-1 modulo 2**WIDTH. Carry <= 1 iff R was 0 (wrap to all ones), else 0.
  - Clear: R <= 0. Carry <= 0.
  - Zero <= 1 iff the new R value is 0.
- No write (En=0 or WrEn=0): all registers, Zero and Carry hold. En=0 dominates WrEn.
- Only register[WrAddr] changes per cycle; all other registers hold.
- Reads are combinational: RdDataX = register[RdAddrX]. A and B may address the same register.
- Read of the register being written in the same cycle returns the pre-edge value unless BYPASS_EN is defined (see below).
- Arithmetic is unsigned and exactly WIDTH bits. No X propagation from unused WrData on non-load ops.

Optional Feature:
- Macro: MU0_REGBANK_BYPASS_EN.
- Defined: when En=1, WrEn=1 and RdAddrX==WrAddr, RdDataX combinationally returns the value that will be written at the next edge, including the inc/dec/clear result. Zero and Carry stay registered, unaffected.
- Undefined: read ports always show current stored contents; no forwarding logic is generated.

Test Plan:
- Reset: drive Reset_n=0 between clock edges with WIDTH=12, RESET_VAL=0 -> all reads 0x000, Zero=1, Carry=0 immediately. Load reg1=0x5A5, then Reset_n=0 mid-cycle -> reg1 reads 0x000 before the next edge.
- Load/read: load reg2=0xABC, reg3=0x123. RdAddrA=2, RdAddrB=3 -> 0xABC, 0x123. Zero=0, Carry=0 after each load.
- Increment wrap: load reg0=0xFFF, then increment reg0 -> reg0=0x000, Zero=1, Carry=1. Increment again -> 0x001, Zero=0, Carry=0.
- Decrement borrow and clear: clear reg1 -> 0x000, Zero=1. Decrement reg1 -> 0xFFF, Carry=1, Zero=0.
- Hold: En=0 with WrEn=1, Op=load, WrData=0x777 on reg2 for 3 cycles -> reg2 stays 0xABC, flags unchanged. En=1, WrEn=0 -> same.
- Same-cycle read of write target: reg3=0x123, increment reg3 with RdAddrA=3 -> before the edge RdDataA=0x123 without bypass, 0x124 with MU0_REGBANK_BYPASS_EN. After the edge 0x124 in both builds.

Source files
------------

// File: rtl/mu0_regbank.sv
// MU0 register bank: 2**ADDR_W registers with one load/inc/dec/clear write port,
// two combinational read ports and registered Zero/Carry. Optional macro: MU0_REGBANK_BYPASS_EN.

module mu0_regbank_cell #(
  parameter int                 WIDTH     = 12,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  q <= RESET_VAL;
    else if (we)   q <= d;
  end
endmodule

module mu0_regbank #(
  parameter int                 WIDTH     = 12,
  parameter int                 ADDR_W    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              En,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              Zero,
  output logic              Carry
);
  localparam int NREGS = 2**ADDR_W;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        op;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

  wr_req_t                        wr;
  logic [NREGS-1:0][WIDTH-1:0]    regs;
  logic [NREGS-1:0]               we;
  logic [WIDTH-1:0]               cur;
  logic [WIDTH-1:0]               nxt;
  logic                           carry_nxt;

  assign wr.vld  = En & WrEn;
  assign wr.addr = WrAddr;
  assign wr.op   = Op;
  assign wr.data = WrData;

  assign cur = regs[wr.addr];

  // WrData only feeds the load path, so an undriven WrData cannot leak into inc/dec/clear.
  always_comb begin
    nxt       = cur;
    carry_nxt = 1'b0;
    case (wr.op)
      OP_LOAD: nxt = wr.data;
      OP_INC: begin
        nxt       = cur + ONE;
        carry_nxt = &cur;
      end
      OP_DEC: begin
        nxt       = cur - ONE;
        carry_nxt = ~|cur;
      end
      OP_CLR:  nxt = '0;
      default: nxt = cur;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      assign we[gi] = wr.vld && (wr.addr == ADDR_W'(gi));
      mu0_regbank_cell #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_cell (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .we      (we[gi]),
        .d       (nxt),
        .q       (regs[gi])
      );
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Zero  <= (RESET_VAL == '0);
      Carry <= 1'b0;
    end else if (wr.vld) begin
      Zero  <= (nxt == '0);
      Carry <= carry_nxt;
    end
  end

`ifdef MU0_REGBANK_BYPASS_EN
  // Forward the pending write result so a same-cycle reader sees the post-edge value.
  assign RdDataA = (wr.vld && RdAddrA == wr.addr) ? nxt : regs[RdAddrA];
  assign RdDataB = (wr.vld && RdAddrB == wr.addr) ? nxt : regs[RdAddrB];
`else
  assign RdDataA = regs[RdAddrA];
  assign RdDataB = regs[RdAddrB];
`endif

endmodule

// File: tb/tb_mu0_regbank.sv
// Randomised + directed bench for mu0_regbank against an arithmetic reference model.
module tb_mu0_regbank;
  localparam int WIDTH  = 12;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 4;
  localparam int MODV   = 4096;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              En, WrEn;
  logic [ADDR_W-1:0] WrAddr, RdAddrA, RdAddrB;
  logic [1:0]        Op;
  logic [WIDTH-1:0]  WrData;
  logic [WIDTH-1:0]  RdDataA, RdDataB;
  logic              Zero, Carry;

  int checks = 0;
  int errors = 0;

  int mreg [NREGS];
  int mzero, mcarry;

  mu0_regbank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RESET_VAL('0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .WrEn(WrEn), .WrAddr(WrAddr),
    .Op(Op), .WrData(WrData), .RdAddrA(RdAddrA), .RdDataA(RdDataA),
    .RdAddrB(RdAddrB), .RdDataB(RdDataB), .Zero(Zero), .Carry(Carry)
  );

  always #5 Clk = ~Clk;

  function automatic int model_next(int v, int op, int d);
    case (op)
      0:       return d;
      1:       return (v + 1) % MODV;
      2:       return (v + MODV - 1) % MODV;
      default: return 0;
    endcase
  endfunction

  function automatic int model_carry(int v, int op);
    if (op == 1) return (v == MODV - 1) ? 1 : 0;
    if (op == 2) return (v == 0) ? 1 : 0;
    return 0;
  endfunction

  // Expected combinational read of address a in the current cycle
  function automatic int exp_read(int a);
`ifdef MU0_REGBANK_BYPASS_EN
    if (En && WrEn && a == int'(WrAddr)) return model_next(mreg[a], int'(Op), int'(WrData));
`endif
    return mreg[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mreg[i] = 0;
    mzero = 1;
    mcarry = 0;
  endtask

  task automatic set_wr(input logic en, input logic we, input int addr, input int op, input int data);
    En = en; WrEn = we; WrAddr = ADDR_W'(addr); Op = 2'(op); WrData = WIDTH'(data);
  endtask

  // Posedge, update model, settle, and return on the following negedge.
  task automatic tick();
    int a, v, n, c;
    a = int'(WrAddr);
    v = mreg[a];
    n = model_next(v, int'(Op), int'(WrData));
    c = model_carry(v, int'(Op));
    @(posedge Clk);
    if (En && WrEn) begin
      mreg[a] = n;
      mzero  = (n == 0) ? 1 : 0;
      mcarry = c;
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b1;
    set_wr(1'b0, 1'b0, 0, 0, 0);
    RdAddrA = '0; RdAddrB = '0;
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NREGS; i++) begin
      RdAddrA = ADDR_W'(i); RdAddrB = ADDR_W'(NREGS - 1 - i);
      #1;
      checks++;
      if (RdDataA !== 12'h000 || RdDataB !== 12'h000) begin
        errors++;
        $display("FAIL reset_read reg%0d: got A=%h B=%h want 000", i, RdDataA, RdDataB);
      end
    end
    checks++;
    if (Zero !== 1'b1 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got Z=%b C=%b want Z=1 C=0", Zero, Carry);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    set_wr(1'b1, 1'b1, 1, 0, 'h5A5);
    RdAddrA = 2'd1;
    tick();
    checks++;
    if (RdDataA !== 12'h5A5 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_preload: got %h Z=%b want 5a5 Z=0", RdDataA, Zero);
    end
    // Reset mid-cycle with a write pending across an edge
    set_wr(1'b1, 1'b1, 2, 0, 'h333);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (RdDataA !== 12'h000 || Zero !== 1'b1 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcycle: got %h Z=%b C=%b want 000 Z=1 C=0", RdDataA, Zero, Carry);
    end
    @(posedge Clk); #1;
    RdAddrB = 2'd2;
    #1;
    checks++;
    if (RdDataB !== 12'h000) begin
      errors++;
      $display("FAIL reset_override: got %h want 000", RdDataB);
    end
    @(negedge Clk);
    set_wr(1'b0, 1'b0, 0, 0, 0);
    Reset_n = 1'b1;
  endtask

  task automatic test_load_read();
    set_wr(1'b1, 1'b1, 2, 0, 'hABC); RdAddrA = 2'd2;
    tick();
    checks++;
    if (RdDataA !== 12'hABC || Zero !== 1'b0 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL load_reg2: got %h Z=%b C=%b want abc Z=0 C=0", RdDataA, Zero, Carry);
    end
    set_wr(1'b1, 1'b1, 3, 0, 'h123);
    tick();
    set_wr(1'b1, 1'b0, 0, 0, 0);
    RdAddrA = 2'd2; RdAddrB = 2'd3;
    #1;
    checks++;
    if (RdDataA !== 12'hABC || RdDataB !== 12'h123 || Zero !== 1'b0 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL load_dual_read: got A=%h B=%h Z=%b C=%b want abc 123 0 0", RdDataA, RdDataB, Zero, Carry);
    end
  endtask

  task automatic test_inc_wrap();
    RdAddrA = 2'd0;
    set_wr(1'b1, 1'b1, 0, 0, 'hFFF);
    tick();
    set_wr(1'b1, 1'b1, 0, 1, 'h555);
    tick();
    checks++;
    if (RdDataA !== 12'h000 || Zero !== 1'b1 || Carry !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap: got %h Z=%b C=%b want 000 Z=1 C=1", RdDataA, Zero, Carry);
    end
    tick();
    checks++;
    if (RdDataA !== 12'h001 || Zero !== 1'b0 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL inc_after_wrap: got %h Z=%b C=%b want 001 Z=0 C=0", RdDataA, Zero, Carry);
    end
  endtask

  task automatic test_dec_clear();
    RdAddrA = 2'd1;
    set_wr(1'b1, 1'b1, 1, 3, 'hFFF);
    tick();
    checks++;
    if (RdDataA !== 12'h000 || Zero !== 1'b1 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL clear: got %h Z=%b C=%b want 000 Z=1 C=0", RdDataA, Zero, Carry);
    end
    set_wr(1'b1, 1'b1, 1, 2, 'h000);
    tick();
    checks++;
    if (RdDataA !== 12'hFFF || Zero !== 1'b0 || Carry !== 1'b1) begin
      errors++;
      $display("FAIL dec_borrow: got %h Z=%b C=%b want fff Z=0 C=1", RdDataA, Zero, Carry);
    end
  endtask

  task automatic test_hold();
    logic z0, c0;
    z0 = Zero; c0 = Carry;
    RdAddrA = 2'd2;
    set_wr(1'b0, 1'b1, 2, 0, 'h777);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (RdDataA !== 12'hABC || Zero !== z0 || Carry !== c0) begin
      errors++;
      $display("FAIL hold_en0: got %h Z=%b C=%b want abc Z=%b C=%b", RdDataA, Zero, Carry, z0, c0);
    end
    set_wr(1'b1, 1'b0, 2, 0, 'h777);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (RdDataA !== 12'hABC || Zero !== z0 || Carry !== c0) begin
      errors++;
      $display("FAIL hold_wren0: got %h Z=%b C=%b want abc Z=%b C=%b", RdDataA, Zero, Carry, z0, c0);
    end
  endtask

  task automatic test_same_cycle();
    logic [WIDTH-1:0] pre;
`ifdef MU0_REGBANK_BYPASS_EN
    pre = 12'h124;
`else
    pre = 12'h123;
`endif
    RdAddrA = 2'd3; RdAddrB = 2'd3;
    set_wr(1'b1, 1'b1, 3, 1, 'h000);
    #1;
    checks++;
    if (RdDataA !== pre || RdDataB !== pre) begin
      errors++;
      $display("FAIL same_cycle_pre: got A=%h B=%h want %h", RdDataA, RdDataB, pre);
    end
    tick();
    set_wr(1'b1, 1'b0, 0, 0, 0);
    #1;
    checks++;
    if (RdDataA !== 12'h124) begin
      errors++;
      $display("FAIL same_cycle_post: got %h want 124", RdDataA);
    end
  endtask

  task automatic test_random();
    int ea, eb;
    for (int n = 0; n < 400; n++) begin
      // Bias toward the wrap boundaries so carry paths get exercised
      int d;
      d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MODV - 1 : 0) : int'($urandom_range(0, MODV - 1));
      set_wr(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
             int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, 3)), d);
      RdAddrA = ADDR_W'($urandom_range(0, NREGS - 1));
      RdAddrB = ADDR_W'($urandom_range(0, NREGS - 1));
      #1;
      ea = exp_read(int'(RdAddrA));
      eb = exp_read(int'(RdAddrB));
      checks++;
      if (RdDataA !== WIDTH'(ea) || RdDataB !== WIDTH'(eb)) begin
        errors++;
        $display("FAIL rand_pre[%0d]: got A=%h B=%h want %h %h", n, RdDataA, RdDataB, ea, eb);
      end
      tick();
      #1;
      checks++;
      if (RdDataA !== WIDTH'(exp_read(int'(RdAddrA))) || Zero !== 1'(mzero) || Carry !== 1'(mcarry)) begin
        errors++;
        $display("FAIL rand_post[%0d]: got A=%h Z=%b C=%b want %h Z=%0d C=%0d",
                 n, RdDataA, Zero, Carry, exp_read(int'(RdAddrA)), mzero, mcarry);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_inc_wrap();
    test_dec_clear();
    test_hold();
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
